// File: rtl/mem_unit_if.sv
// Memory request/reply bundle shared by the pulse distributor, op unit, arithmetic unit and I/O.
// The master drives requests, write data and overrun clear; the slave (mem_unit) drives replies and status.
interface mem_unit_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 31
);
   logic              mem_read_from_pu;
   logic              mem_write_from_op;
   logic [ADDR_W-1:0] addr_from_sel;
   logic [DATA_W-1:0] data_from_ac;
   logic              mem_read_reply_to_pu;
   logic              mem_write_reply_to_op;
   logic [DATA_W-1:0] data_to_ac;
   logic              busy_to_io;
   logic              overrun_to_io;
   logic              clr_overrun_from_io;

   modport master (
      output mem_read_from_pu, mem_write_from_op, addr_from_sel, data_from_ac,
             clr_overrun_from_io,
      input  mem_read_reply_to_pu, mem_write_reply_to_op, data_to_ac,
             busy_to_io, overrun_to_io
   );

   modport slave (
      input  mem_read_from_pu, mem_write_from_op, addr_from_sel, data_from_ac,
             clr_overrun_from_io,
      output mem_read_reply_to_pu, mem_write_reply_to_op, data_to_ac,
             busy_to_io, overrun_to_io
   );
endinterface

// File: rtl/mem_unit.sv
// Main-store responder: one request at a time, IDLE -> SEEK -> XFER -> REPLY -> IDLE.
// Define DRUM_LATENCY_EN to model drum rotational latency during SEEK.
module mem_unit #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 31,
   parameter int SEC_W       = 5,
   parameter int SECTOR_CLKS = 4
) (
   input logic       clk,
   input logic       resetn,
   mem_unit_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, SEEK, XFER, REPLY} state_t;

   state_t            state;
   logic              op_rd;
   logic [ADDR_W-1:0] addr_lat;
   logic [DATA_W-1:0] data_lat;
   logic              rd_reply;
   logic              wr_reply;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic              overrun;
   logic              seek_done;
   logic              rd_req;
   logic              wr_req;
   logic              set_overrun;

   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_req = bus.mem_read_from_pu;
   assign wr_req = bus.mem_write_from_op;

   // Dropped requests: anything while busy, or the write half of a read+write collision.
   assign set_overrun = (state != IDLE) ? (rd_req || wr_req) : (rd_req && wr_req);

`ifdef DRUM_LATENCY_EN
   localparam int DIV_W = (SECTOR_CLKS > 1) ? $clog2(SECTOR_CLKS) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic [SEC_W-1:0] sec_pos;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt <= '0;
         sec_pos <= '0;
      end else if (div_cnt == DIV_W'(SECTOR_CLKS - 1)) begin
         div_cnt <= '0;
         sec_pos <= sec_pos + SEC_W'(1);
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign seek_done = (sec_pos == addr_lat[SEC_W-1:0]) && (div_cnt == '0);
`else
   // Without the drum model every seek completes at once; an illegal geometry never does.
   assign seek_done = (SEC_W <= ADDR_W) && (SECTOR_CLKS >= 1);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         op_rd    <= 1'b0;
         addr_lat <= '0;
         data_lat <= '0;
         rd_reply <= 1'b0;
         wr_reply <= 1'b0;
         data_out <= '0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rd_reply <= 1'b0;
         wr_reply <= 1'b0;

         if (set_overrun) begin
            overrun <= 1'b1;
         end else if (bus.clr_overrun_from_io) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rd_req || wr_req) begin
                  op_rd    <= rd_req;
                  addr_lat <= bus.addr_from_sel;
                  data_lat <= bus.data_from_ac;
                  busy     <= 1'b1;
                  state    <= SEEK;
               end
            end
            SEEK: begin
               if (seek_done) begin
                  state <= XFER;
               end
            end
            XFER: begin
               if (op_rd) begin
                  data_out <= mem[addr_lat];
               end
               rd_reply <= op_rd;
               wr_reply <= !op_rd;
               state    <= REPLY;
            end
            REPLY: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Storage has no reset; an async reset forces IDLE, so an aborted write never reaches XFER.
   always_ff @(posedge clk) begin
      if (state == XFER && !op_rd) begin
         mem[addr_lat] <= data_lat;
      end
   end

   assign bus.mem_read_reply_to_pu  = rd_reply;
   assign bus.mem_write_reply_to_op = wr_reply;
   assign bus.data_to_ac            = data_out;
   assign bus.busy_to_io            = busy;
   assign bus.overrun_to_io         = overrun;
endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed scenarios plus randomized traffic against a
// reference store, a cycle-arithmetic latency model and an overrun flag model.
module tb_mem_unit;
   localparam int ADDR_W      = 11;
   localparam int DATA_W      = 31;
   localparam int SEC_W       = 5;
   localparam int SECTOR_CLKS = 4;
`ifdef DRUM_LATENCY_EN
   localparam bit DRUM = 1'b1;
`else
   localparam bit DRUM = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   ncyc = 0;
   bit   ovr = 1'b0;

   logic [DATA_W-1:0] ref_mem [int];
   int                written [$];

   mem_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_unit #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .SEC_W(SEC_W),
      .SECTOR_CLKS(SECTOR_CLKS)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; the drum position is a pure function of this.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) ncyc <= 0;
      else         ncyc <= ncyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reply cycle offset from request cycle t: first SEEK cycle (>= t+1) aligned with the sector, plus 2.
   function automatic int exp_lat(input int t, input logic [ADDR_W-1:0] a);
      int nsec;
      nsec = 1 << SEC_W;
      if (!DRUM) return 3;
      for (int c = t + 1; c <= t + 1 + SECTOR_CLKS * nsec; c++) begin
         if ((c % SECTOR_CLKS) == 0 && ((c / SECTOR_CLKS) % nsec) == (int'(a) % nsec))
            return c - t + 2;
      end
      return -1;
   endfunction

   // Called on a negedge; drives the request in the current cycle and ends on the negedge after REPLY.
   task automatic run_op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int inj_in, input bit clr_with_inj);
      int lat;
      int inj;
      int nrd;
      int nwr;
      int first;
      nrd   = 0;
      nwr   = 0;
      first = -1;
      lat   = exp_lat(ncyc, a);
      inj   = inj_in;
      if (inj < 0) inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat)) : 0;
      bus.mem_read_from_pu  = rd;
      bus.mem_write_from_op = wr;
      bus.addr_from_sel     = a;
      bus.data_from_ac      = d;
      if (rd && wr) ovr = 1'b1;
      for (int i = 1; i <= lat + 1; i++) begin
         @(negedge clk);
         if (bus.mem_read_reply_to_pu === 1'b1) begin
            nrd++;
            if (first < 0) first = i;
         end
         if (bus.mem_write_reply_to_op === 1'b1) begin
            nwr++;
            if (first < 0) first = i;
         end
         chk((i <= lat) ? "busy_high" : "busy_low", 64'(bus.busy_to_io), 64'(i <= lat));
         if (rd && i == lat) chk("read_data", 64'(bus.data_to_ac), 64'(ref_mem[int'(a)]));
         bus.mem_read_from_pu    = 1'b0;
         bus.mem_write_from_op   = 1'b0;
         bus.clr_overrun_from_io = 1'b0;
         bus.addr_from_sel       = ADDR_W'($urandom);
         bus.data_from_ac        = DATA_W'($urandom);
         if (i == inj) begin
            bus.mem_read_from_pu    = 1'b1;
            bus.mem_write_from_op   = 1'($urandom_range(0, 1));
            bus.clr_overrun_from_io = clr_with_inj;
            ovr = 1'b1;
         end
      end
      if (wr && !rd) begin
         if (!ref_mem.exists(int'(a))) written.push_back(int'(a));
         ref_mem[int'(a)] = d;
      end
      chk("read_reply_count", 64'(nrd), 64'(rd));
      chk("write_reply_count", 64'(nwr), 64'(wr && !rd));
      chk("reply_cycle", 64'(first), 64'(lat));
      chk("overrun", 64'(bus.overrun_to_io), 64'(ovr));
   endtask

   task automatic clr_pulse();
      bus.clr_overrun_from_io = 1'b1;
      @(negedge clk);
      bus.clr_overrun_from_io = 1'b0;
      ovr = 1'b0;
      chk("overrun_cleared", 64'(bus.overrun_to_io), 64'(0));
   endtask

   initial begin
      bus.mem_read_from_pu    = 1'b0;
      bus.mem_write_from_op   = 1'b0;
      bus.addr_from_sel       = '0;
      bus.data_from_ac        = '0;
      bus.clr_overrun_from_io = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy_to_io), 64'(0));
      chk("rst_overrun", 64'(bus.overrun_to_io), 64'(0));
      chk("rst_rd_reply", 64'(bus.mem_read_reply_to_pu), 64'(0));
      chk("rst_wr_reply", 64'(bus.mem_write_reply_to_op), 64'(0));
      chk("rst_data", 64'(bus.data_to_ac), 64'(0));
      resetn = 1'b1;
      @(negedge clk);

      // write then read back-to-back (second request in the cycle after REPLY)
      run_op(1'b0, 1'b1, 11'd5, 31'h1234, 0, 1'b0);
      run_op(1'b1, 1'b0, 11'd5, 31'h0, 0, 1'b0);

      // second read one cycle after the first is dropped
      run_op(1'b1, 1'b0, 11'd5, 31'h0, 1, 1'b0);
      clr_pulse();

      // read and write together: read wins, memory unchanged
      run_op(1'b0, 1'b1, 11'd9, 31'h0ABC, 0, 1'b0);
      run_op(1'b1, 1'b1, 11'd9, 31'h7FFF_0000, 0, 1'b0);
      run_op(1'b1, 1'b0, 11'd9, 31'h0, 0, 1'b0);
      clr_pulse();

      // set and clear in the same cycle: set wins
      run_op(1'b0, 1'b1, 11'd12, 31'h55AA, 2, 1'b1);
      clr_pulse();

      // reset during SEEK aborts a write
      run_op(1'b0, 1'b1, 11'd7, 31'h777, 0, 1'b0);
      run_op(1'b0, 1'b1, 11'd8, 31'h888, 1, 1'b0);
      bus.mem_write_from_op = 1'b1;
      bus.addr_from_sel     = 11'd7;
      bus.data_from_ac      = 31'h1111;
      @(negedge clk);
      chk("seek_busy", 64'(bus.busy_to_io), 64'(1));
      bus.mem_write_from_op = 1'b0;
      resetn = 1'b0;
      ovr    = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy_to_io), 64'(0));
      chk("abort_overrun", 64'(bus.overrun_to_io), 64'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_reply", 64'(bus.mem_read_reply_to_pu | bus.mem_write_reply_to_op), 64'(0));
      end
      resetn = 1'b1;
      @(negedge clk);
      run_op(1'b1, 1'b0, 11'd7, 31'h0, 0, 1'b0);
      run_op(1'b1, 1'b0, 11'd8, 31'h0, 0, 1'b0);

      // drum: wait for sector 3 at div 0, then a read whose sector just passed
      if (DRUM) begin
         run_op(1'b0, 1'b1, 11'd2, 31'h2222, 0, 1'b0);
         for (int i = 0; i < 2 * SECTOR_CLKS * (1 << SEC_W); i++) begin
            if ((ncyc % SECTOR_CLKS) == 0 && ((ncyc / SECTOR_CLKS) % (1 << SEC_W)) == 3) break;
            @(negedge clk);
         end
         run_op(1'b1, 1'b0, 11'd2, 31'h0, 0, 1'b0);
         for (int i = 0; i < 2 * SECTOR_CLKS * (1 << SEC_W); i++) begin
            if ((ncyc % SECTOR_CLKS) == 0 && ((ncyc / SECTOR_CLKS) % (1 << SEC_W)) == 3) break;
            @(negedge clk);
         end
         run_op(1'b1, 1'b0, 11'd3, 31'h0, 0, 1'b0);
         run_op(1'b1, 1'b0, 11'd3, 31'h0, 40, 1'b0);
         clr_pulse();
      end

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         int sel;
         logic [ADDR_W-1:0] a;
         sel = int'($urandom_range(0, 9));
         if (sel < 4 || written.size() == 0) begin
            a = ADDR_W'($urandom);
            run_op(1'b0, 1'b1, a, DATA_W'($urandom), -1, 1'($urandom_range(0, 1)));
         end else begin
            a = ADDR_W'(written[$urandom_range(0, written.size() - 1)]);
            run_op(1'b1, (sel == 9), a, DATA_W'($urandom), -1, 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 3) == 0) clr_pulse();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
